// File: rtl/any1_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : any1_pkg
// Brief  : Shared bus widths and bus-RAM state encoding for the ANY-1 bus.
// Rev    : 1.0  initial release
// ============================================================================
package any1_pkg;

    localparam int BUS_DATA_W = 128;
    localparam int BUS_SEL_W  = 16;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_WAIT = 2'd1,
        BR_RESP = 2'd2
    } bus_ram_state_e;

endpackage
`default_nettype wire

// File: rtl/any1_bus_ram_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : any1_bus_ram_array
// Brief  : Single-port 2**DEPTH_LOG2 x 128 RAM, byte-lane writes, registered read.
// Rev    : 1.0  initial release
// ============================================================================
module any1_bus_ram_array
    import any1_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_adr,
    input  logic [BUS_SEL_W-1:0]  i_sel,
    input  logic [BUS_DATA_W-1:0] i_dat,
    output logic [BUS_DATA_W-1:0] o_dat
);

    logic [BUS_DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [BUS_DATA_W-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (i_en && i_we) begin
            for (int b = 0; b < BUS_SEL_W; b++) begin
                if (i_sel[b]) begin
                    r_mem[i_adr][8*b +: 8] <= i_dat[8*b +: 8];
                end
            end
        end
    end

    // The read register only moves on reads, so writes leave the output alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else if (i_en && !i_we) begin
            r_q <= r_mem[i_adr];
        end
    end

    assign o_dat = r_q;

endmodule
`default_nettype wire

// File: rtl/any1_bus_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : any1_bus_ram
// Brief  : ANY-1 bus RAM slave with programmable wait states and registered ack.
//          Define ANY1_BUS_RAM_ERR_EN to claim misses and answer them with err_o.
// Rev    : 1.0  initial release
// ============================================================================
module any1_bus_ram
    import any1_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [BUS_SEL_W-1:0]  sel_i,
    input  logic [31:0]           adr_i,
    input  logic [BUS_DATA_W-1:0] dat_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [BUS_DATA_W-1:0] dat_o
);

    localparam int         c_TAG_LSB   = DEPTH_LOG2 + 4;
    localparam logic [3:0] c_WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    bus_ram_state_e        r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_adr;
    logic                  r_we;
    logic [BUS_SEL_W-1:0]  r_sel;
    logic [BUS_DATA_W-1:0] r_dat;
    logic                  r_miss;
    logic                  r_ack;

    logic                  w_req;
    logic                  w_hit;
    logic                  w_claim;
    logic                  w_idle;
    logic                  w_enter_resp;
    logic                  w_miss_now;
    logic                  w_ram_en;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-1:0] w_ram_adr;
    logic [BUS_SEL_W-1:0]  w_ram_sel;
    logic [BUS_DATA_W-1:0] w_ram_dat;
    logic                  w_unused;

    assign w_req    = cyc_i & stb_i;
    assign w_hit    = (adr_i[31:c_TAG_LSB] == BASE[31:c_TAG_LSB]);
    assign w_idle   = (r_state == BR_IDLE);
    assign w_unused = ^adr_i[3:0];

`ifdef ANY1_BUS_RAM_ERR_EN
    logic r_err;
    assign w_claim = w_req;
    assign err_o   = r_err;
`else
    assign w_claim = w_req & w_hit;
    assign err_o   = 1'b0;
`endif

    // With zero wait states the RAM is accessed on the sampling edge itself,
    // so in IDLE the RAM sees the live bus rather than the latched request.
    assign w_enter_resp = (w_idle && w_claim && (WAIT_STATES == 0)) ||
                          ((r_state == BR_WAIT) && w_req && (r_cnt == 4'd0));
    assign w_miss_now   = w_idle ? ~w_hit : r_miss;
    assign w_ram_en     = w_enter_resp & ~w_miss_now;
    assign w_ram_we     = w_idle ? we_i : r_we;
    assign w_ram_adr    = w_idle ? adr_i[c_TAG_LSB-1:4] : r_adr;
    assign w_ram_sel    = w_idle ? sel_i : r_sel;
    assign w_ram_dat    = w_idle ? dat_i : r_dat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= BR_IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_miss  <= 1'b0;
            r_ack   <= 1'b0;
`ifdef ANY1_BUS_RAM_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                BR_IDLE: begin
                    r_ack <= 1'b0;
`ifdef ANY1_BUS_RAM_ERR_EN
                    r_err <= 1'b0;
`endif
                    if (w_claim) begin
                        r_adr  <= adr_i[c_TAG_LSB-1:4];
                        r_we   <= we_i;
                        r_sel  <= sel_i;
                        r_dat  <= dat_i;
                        r_miss <= ~w_hit;
                        if (WAIT_STATES == 0) begin
                            r_state <= BR_RESP;
                        end else begin
                            r_state <= BR_WAIT;
                            r_cnt   <= c_WAIT_INIT;
                        end
                    end
                end
                BR_WAIT: begin
                    if (!w_req) begin
                        r_state <= BR_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= BR_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                BR_RESP: begin
                    if (w_req) begin
                        r_ack <= ~r_miss;
`ifdef ANY1_BUS_RAM_ERR_EN
                        r_err <= r_miss;
`endif
                    end else begin
                        r_state <= BR_IDLE;
                        r_ack   <= 1'b0;
`ifdef ANY1_BUS_RAM_ERR_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= BR_IDLE;
                end
            endcase
        end
    end

    assign ack_o = r_ack;

    any1_bus_ram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .i_en  (w_ram_en),
        .i_we  (w_ram_we),
        .i_adr (w_ram_adr),
        .i_sel (w_ram_sel),
        .i_dat (w_ram_dat),
        .o_dat (dat_o)
    );

endmodule
`default_nettype wire
